// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit output register.
// Grants are registered and one-hot; a burst limit rotates the grant under contention.
module rr_shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 2
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     data,
    output logic [N-1:0]           gnt,
    output logic [WIDTH-1:0]       O,
    output logic                   O_valid,
    output logic [$clog2(N)-1:0]   O_src
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    holder;
    logic [WIDTH-1:0] hdata;
    logic             xfer;
    logic             at_limit;
    logic [N-1:0]     others;
    logic [IW-1:0]    win_all;
    logic [IW-1:0]    win_oth;

    // First set bit of mask, scanning upward from start with wrap-around.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] mask, input logic [IW-1:0] start);
        logic [IW-1:0] sel;
        logic          found;
        int unsigned   j;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(start) + k) % N;
            if (!found && mask[IW'(j)]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
        return sel;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
        return (w == IW'(N - 1)) ? '0 : w + 1'b1;
    endfunction

    always_comb begin
        holder = '0;
        hdata  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                holder = IW'(i);
                hdata  = data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer     = |(gnt & req);
    assign at_limit = (cnt == CW'(MAX_HOLD - 1));
    assign others   = req & ~gnt;
    assign win_all  = pick(req, ptr);
    assign win_oth  = pick(others, ptr);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            gnt     <= '0;
            O       <= '0;
            O_valid <= 1'b0;
            O_src   <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            O_valid <= xfer;
            if (xfer) begin
                O     <= hdata;
                O_src <= holder;
            end
            // No transfer covers both "no holder" and "holder dropped its request".
            if (!xfer) begin
                cnt <= '0;
                if (|req) begin
                    gnt <= N'(1) << win_all;
                    ptr <= next_ptr(win_all);
                end else begin
                    gnt <= '0;
                end
            end else if (at_limit) begin
                cnt <= '0;
                if (|others) begin
                    gnt <= N'(1) << win_oth;
                    ptr <= next_ptr(win_oth);
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    a_gnt_onehot0: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(gnt));

    a_idle_grants: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (req != '0 && gnt == '0) |-> ##1 (gnt != '0));

    for (genvar i = 0; i < N; i++) begin : g_sva
        a_xfer_loads: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            (gnt[i] && req[i]) |-> ##1 (O_valid && O_src == IW'(i)));

        a_gnt_had_req: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            gnt[i] |-> $past(req[i]));
    end

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Directed bench for rr_shared_reg_arbiter (N=4, WIDTH=8, MAX_HOLD=2).
module tb_rr_shared_reg_arbiter;

    localparam int N        = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 2;

    logic                 CLK = 1'b0;
    logic                 ASYNCRESETN;
    logic [N-1:0]         req;
    logic [N*WIDTH-1:0]   data;
    logic [N-1:0]         gnt;
    logic [WIDTH-1:0]     O;
    logic                 O_valid;
    logic [1:0]           O_src;

    int checks   = 0;
    int failures = 0;

    rr_shared_reg_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .req(req),
        .data(data),
        .gnt(gnt),
        .O(O),
        .O_valid(O_valid),
        .O_src(O_src)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        tick();
        tick();
        ASYNCRESETN = 1'b1;
    endtask

    logic [3:0] exp_g   [1:11];
    logic [1:0] exp_src [2:11];
    logic [7:0] dv      [0:3];

    initial begin
        dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h5A; dv[3] = 8'h83;
        data = {dv[3], dv[2], dv[1], dv[0]};
        exp_g[1] = 4'b0001; exp_g[2]  = 4'b0001; exp_g[3]  = 4'b0010; exp_g[4] = 4'b0010;
        exp_g[5] = 4'b0100; exp_g[6]  = 4'b0100; exp_g[7]  = 4'b1000; exp_g[8] = 4'b1000;
        exp_g[9] = 4'b0001; exp_g[10] = 4'b0001; exp_g[11] = 4'b0010;
        exp_src[2] = 2'd0; exp_src[3] = 2'd0; exp_src[4]  = 2'd1; exp_src[5]  = 2'd1;
        exp_src[6] = 2'd2; exp_src[7] = 2'd2; exp_src[8]  = 2'd3; exp_src[9]  = 2'd3;
        exp_src[10] = 2'd0; exp_src[11] = 2'd0;

        // Reset with all requesters active
        ASYNCRESETN = 1'b0;
        req = 4'b1111;
        #2;
        chk("rst_async_gnt", 32'(gnt), 32'h0);
        tick(); tick(); tick();
        chk("rst_hold_gnt", 32'(gnt), 32'h0);
        chk("rst_O", 32'(O), 32'h0);
        chk("rst_O_valid", 32'(O_valid), 32'h0);
        chk("rst_O_src", 32'(O_src), 32'h0);
        req = 4'b0000;
        ASYNCRESETN = 1'b1;
        #1;
        chk("rel_gnt", 32'(gnt), 32'h0);

        // Single requester holds indefinitely
        req = 4'b0100;
        tick();
        chk("single_gnt_e1", 32'(gnt), 32'b0100);
        chk("single_valid_e1", 32'(O_valid), 32'h0);
        tick();
        chk("single_O", 32'(O), 32'h5A);
        chk("single_valid_e2", 32'(O_valid), 32'h1);
        chk("single_src", 32'(O_src), 32'd2);
        for (int t = 3; t <= 6; t++) begin
            tick();
            chk($sformatf("single_hold_gnt_e%0d", t), 32'(gnt), 32'b0100);
            chk($sformatf("single_hold_valid_e%0d", t), 32'(O_valid), 32'h1);
        end
        req = 4'b0000;
        tick();
        chk("single_drop_gnt", 32'(gnt), 32'h0);
        chk("single_drop_valid", 32'(O_valid), 32'h0);
        chk("single_drop_O", 32'(O), 32'h5A);

        // Full contention with burst limit
        do_reset();
        req = 4'b1111;
        for (int t = 1; t <= 11; t++) begin
            tick();
            chk($sformatf("cont_gnt_t%0d", t), 32'(gnt), 32'(exp_g[t]));
            if (t == 1) begin
                chk("cont_valid_t1", 32'(O_valid), 32'h0);
            end else begin
                chk($sformatf("cont_valid_t%0d", t), 32'(O_valid), 32'h1);
                chk($sformatf("cont_src_t%0d", t), 32'(O_src), 32'(exp_src[t]));
                chk($sformatf("cont_O_t%0d", t), 32'(O), 32'(dv[exp_src[t]]));
            end
        end

        // Asynchronous reset mid-burst, between edges
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_valid", 32'(O_valid), 32'h0);
        chk("midrst_O", 32'(O), 32'h0);
        tick();
        ASYNCRESETN = 1'b1;
        tick();
        chk("midrst_regrant", 32'(gnt), 32'b0001);
        chk("midrst_valid_e1", 32'(O_valid), 32'h0);
        tick();
        chk("midrst_gnt_e2", 32'(gnt), 32'b0001);
        chk("midrst_src_e2", 32'(O_src), 32'd0);
        chk("midrst_O_e2", 32'(O), 32'h10);

        // Early release costs one dead cycle
        do_reset();
        req = 4'b1001;
        tick();
        chk("early_gnt_c1", 32'(gnt), 32'b0001);
        chk("early_valid_c1", 32'(O_valid), 32'h0);
        tick();
        chk("early_gnt_c2", 32'(gnt), 32'b0001);
        chk("early_valid_c2", 32'(O_valid), 32'h1);
        chk("early_O_c2", 32'(O), 32'h10);
        req = 4'b1000;
        tick();
        chk("early_gnt_c3", 32'(gnt), 32'b1000);
        chk("early_valid_c3", 32'(O_valid), 32'h0);
        chk("early_O_c3", 32'(O), 32'h10);
        tick();
        chk("early_gnt_c4", 32'(gnt), 32'b1000);
        chk("early_valid_c4", 32'(O_valid), 32'h1);
        chk("early_src_c4", 32'(O_src), 32'd3);
        chk("early_O_c4", 32'(O), 32'h83);

        // Idle after requester 1 holds
        do_reset();
        req = 4'b0010;
        tick();
        chk("idle_gnt_e1", 32'(gnt), 32'b0010);
        tick();
        chk("idle_valid_e2", 32'(O_valid), 32'h1);
        chk("idle_src_e2", 32'(O_src), 32'd1);
        chk("idle_O_e2", 32'(O), 32'h21);
        req = 4'b0000;
        tick();
        chk("idle_gnt_e3", 32'(gnt), 32'h0);
        chk("idle_valid_e3", 32'(O_valid), 32'h0);
        chk("idle_O_e3", 32'(O), 32'h21);
        chk("idle_src_e3", 32'(O_src), 32'd1);
        tick();
        chk("idle_gnt_e4", 32'(gnt), 32'h0);
        chk("idle_valid_e4", 32'(O_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
